reg_share_arbiter: RTL and testbench
====================================

# reg_share_arbiter

Round-robin arbiter and controller for the shared 8-bit register stage. It lets up to N_REQ requesters take turns loading the register, grants each winner ownership for a fixed number of cycles, and drives the register's complementary q/q_bar outputs. It sits between requester logic and downstream consumers of the register value and replaces direct, uncontrolled loading of the register.

## Interface
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width.
- HOLD_CYCLES, 2, cycles of ownership per grant (>= 1).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  in  N_REQ  request level, bit i belongs to requester i.
- data_in  in  N_REQ*WIDTH  requester i's data at bits [i*WIDTH +: WIDTH].
- grant  out  N_REQ  one-hot ownership level; all zero when no owner.
- ack  out  N_REQ  one-hot, one-cycle pulse marking the first cycle of a grant.
- owner  out  clog2(N_REQ)  index of the current or last owner.
- busy  out  1  high while grant != 0.
- q  out  WIDTH  shared register value.
- q_bar  out  WIDTH  bitwise complement of q, always.

## Operation
- States: IDLE (no owner) and HOLD (owner active, down-counter hold_cnt).
- Round-robin pointer ptr is the index searched first. Scan order is ptr, ptr+1, …, wrapping mod N_REQ. The first requester found with req set wins.
- Arbitration edge: in IDLE with any req set, or in HOLD with hold_cnt==0 and any req set:
  - q <= winner's data_in slice.
  - grant <= onehot(winner).
  - ack <= onehot(winner).
  - owner <= winner.
  - hold_cnt <= HOLD_CYCLES-1.
  - ptr <= (winner+1) mod N_REQ.
  - State goes to or stays in HOLD.
- HOLD with hold_cnt != 0:
  - hold_cnt decrements.
  - q, grant, owner and ptr are frozen.
  - ack is 0.
  - Changes to data_in and req are ignored, including the owner dropping req.
- HOLD with hold_cnt==0 and no req set: grant <= 0, ack <= 0, state goes to IDLE. q and owner keep their last values.
- IDLE with no req: all registers hold. ack is 0.
- q is loaded only at an arbitration edge and cleared only by rst.
- q_bar is ~q at all times, with no separate state.
- Reset (rst=1 at an edge, from any state, including mid-HOLD):
  - q=0, q_bar=all ones.
  - grant=0, ack=0, owner=0, busy=0.
  - ptr=0, hold_cnt=0, state IDLE.
  - Ongoing ownership is aborted. rst has priority over arbitration in the same cycle.

## Timing
- req and data_in are sampled at the rising edge. If req is set during IDLE cycle k, then in cycle k+1 grant, ack, owner and q are all valid (1-cycle latency).
- Ownership lasts exactly HOLD_CYCLES cycles (k+1 … k+HOLD_CYCLES).
- ack is high only in cycle k+1.
- With continuous requests, the next grant starts in cycle k+HOLD_CYCLES+1. There is no idle gap between back-to-back grants, and the ack pulses of consecutive grants are HOLD_CYCLES apart.
- After the last grant ends with no requests pending: grant=0 and busy=0 from cycle k+HOLD_CYCLES+1.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
All scenarios use N_REQ=4, WIDTH=8, HOLD_CYCLES=2.
- Reset: hold rst=1 for 2 cycles with req=4'b1111 → q=8'h00, q_bar=8'hFF, grant=0, ack=0, busy=0, owner=0.
- Single request: req=4'b0100 with data2=23; change data2 to 2 during ownership → grant=4'b0100 for 2 cycles, ack=4'b0100 for 1 cycle, owner=2, q=23 (q_bar=8'hE8) throughout. q stays 23 after grant drops.
- Round robin: req=4'b1111 held, data0..3=11,50,60,112 → grants 0,1,2,3,0 in turn, each 2 cycles with no gaps. q sequence is 11,50,60,112,11 and ack pulses are every 2 cycles.
- Pointer wrap: after a grant to 3, apply req=4'b1001 → next grant goes to 0. After that grant, with req still 4'b1001 → next grant goes to 3.
- Reset mid-hold: assert rst in the second cycle of a grant to requester 1 (q=50) → at the next edge q=0, grant=0. A subsequent req=4'b1111 grants requester 0 first (ptr=0).
- Owner drops request: owner 2 deasserts req in its first HOLD cycle while req1 is still set → grant to 2 still lasts 2 cycles, then grant moves to 1 with no gap.

Source files
------------

// File: rtl/reg_share_if.sv
// reg_share_if: requester/consumer bundle for the shared register arbiter.
interface reg_share_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int OW = $clog2(N_REQ);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] data_in;
   logic [N_REQ-1:0]       grant;
   logic [N_REQ-1:0]       ack;
   logic [OW-1:0]          owner;
   logic                   busy;
   logic [WIDTH-1:0]       q;
   logic [WIDTH-1:0]       q_bar;
   modport master (output req, data_in, input grant, ack, owner, busy, q, q_bar);
   modport slave  (input req, data_in, output grant, ack, owner, busy, q, q_bar);
endinterface

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin ownership of a shared register with fixed hold time.
module reg_share_arbiter #(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   reg_share_if.slave bus
);
   localparam int OW = $clog2(N_REQ);
   localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   typedef enum logic {IDLE, HOLD} state_t;
   state_t           state, nxt_state;
   logic [N_REQ-1:0] grant, nxt_grant, ack, nxt_ack;
   logic [OW-1:0]    owner, nxt_owner, ptr, nxt_ptr, win;
   logic [CW-1:0]    cnt, nxt_cnt;
   logic [WIDTH-1:0] q, nxt_q;
   logic             found, arb, keep;
   // descending scan so the lowest offset from ptr is the final assignment
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req[(int'(ptr) + i) % N_REQ]) begin
            found = 1'b1;
            win   = OW'((int'(ptr) + i) % N_REQ);
         end
      end
   end
   always_comb begin
      arb       = found && (state == IDLE || cnt == '0);
      keep      = state == HOLD && cnt != '0;
      nxt_state = (arb || keep) ? HOLD : IDLE;
      nxt_grant = arb ? N_REQ'(1) << win : keep ? grant : '0;
      nxt_ack   = arb ? N_REQ'(1) << win : '0;
      nxt_owner = arb ? win : owner;
      nxt_ptr   = arb ? OW'((int'(win) + 1) % N_REQ) : ptr;
      nxt_q     = arb ? bus.data_in[int'(win)*WIDTH +: WIDTH] : q;
      nxt_cnt   = arb ? CW'(HOLD_CYCLES - 1) : keep ? cnt - 1'b1 : cnt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ack   <= '0;
         owner <= '0;
         ptr   <= '0;
         cnt   <= '0;
         q     <= '0;
      end else begin
         state <= nxt_state;
         grant <= nxt_grant;
         ack   <= nxt_ack;
         owner <= nxt_owner;
         ptr   <= nxt_ptr;
         cnt   <= nxt_cnt;
         q     <= nxt_q;
      end
   end
   assign bus.grant = grant;
   assign bus.ack   = ack;
   assign bus.owner = owner;
   assign bus.busy  = |grant;
   assign bus.q     = q;
   assign bus.q_bar = ~q;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed scenarios for the round-robin shared register arbiter.
module tb_reg_share_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int errors = 0;
   reg_share_if #(.N_REQ(4), .WIDTH(8)) bus();
   reg_share_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.req = 4'b1111;
      bus.data_in = {8'd112, 8'd60, 8'd50, 8'd11};
      tick();
      tick();
      checks++;
      if ({bus.q, bus.q_bar, bus.grant, bus.ack, bus.busy, bus.owner} !== {8'h00, 8'hFF, 4'b0, 4'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL reset: q=%h q_bar=%h grant=%b ack=%b busy=%b owner=%0d, want 00 ff 0000 0000 0 0", bus.q, bus.q_bar, bus.grant, bus.ack, bus.busy, bus.owner);
      end
      rst = 1'b0;
      bus.req = 4'b0000;
      tick();
      checks++;
      if ({bus.grant, bus.busy} !== {4'b0, 1'b0}) begin
         errors++;
         $display("FAIL idle_after_reset: grant=%b busy=%b, want 0000 0", bus.grant, bus.busy);
      end
   endtask
   task automatic test_single();
      bus.data_in = {8'd112, 8'd23, 8'd50, 8'd11};
      bus.req = 4'b0100;
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.owner, bus.q, bus.q_bar, bus.busy} !== {4'b0100, 4'b0100, 2'd2, 8'd23, 8'hE8, 1'b1}) begin
         errors++;
         $display("FAIL single_c1: grant=%b ack=%b owner=%0d q=%0d q_bar=%h busy=%b, want 0100 0100 2 23 e8 1", bus.grant, bus.ack, bus.owner, bus.q, bus.q_bar, bus.busy);
      end
      bus.data_in = {8'd112, 8'd2, 8'd50, 8'd11};
      bus.req = 4'b0000;
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.owner, bus.q} !== {4'b0100, 4'b0000, 2'd2, 8'd23}) begin
         errors++;
         $display("FAIL single_c2: grant=%b ack=%b owner=%0d q=%0d, want 0100 0000 2 23", bus.grant, bus.ack, bus.owner, bus.q);
      end
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.busy, bus.owner, bus.q, bus.q_bar} !== {4'b0, 4'b0, 1'b0, 2'd2, 8'd23, 8'hE8}) begin
         errors++;
         $display("FAIL single_end: grant=%b ack=%b busy=%b owner=%0d q=%0d q_bar=%h, want 0000 0000 0 2 23 e8", bus.grant, bus.ack, bus.busy, bus.owner, bus.q, bus.q_bar);
      end
   endtask
   task automatic test_round_robin();
      logic [7:0] dat [4] = '{8'd11, 8'd50, 8'd60, 8'd112};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.data_in = {8'd112, 8'd60, 8'd50, 8'd11};
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if ({bus.grant, bus.ack, bus.owner, bus.q} !== {4'(1 << (n % 4)), 4'(1 << (n % 4)), 2'(n % 4), dat[n % 4]}) begin
            errors++;
            $display("FAIL rr_first_%0d: grant=%b ack=%b owner=%0d q=%0d, want idx %0d q=%0d", n, bus.grant, bus.ack, bus.owner, bus.q, n % 4, dat[n % 4]);
         end
         tick();
         checks++;
         if ({bus.grant, bus.ack, bus.q} !== {4'(1 << (n % 4)), 4'b0, dat[n % 4]}) begin
            errors++;
            $display("FAIL rr_second_%0d: grant=%b ack=%b q=%0d, want idx %0d ack 0 q=%0d", n, bus.grant, bus.ack, bus.q, n % 4, dat[n % 4]);
         end
      end
   endtask
   task automatic test_pointer_wrap();
      bus.req = 4'b1000;
      tick();
      checks++;
      if ({bus.grant, bus.owner, bus.q} !== {4'b1000, 2'd3, 8'd112}) begin
         errors++;
         $display("FAIL wrap_to3: grant=%b owner=%0d q=%0d, want 1000 3 112", bus.grant, bus.owner, bus.q);
      end
      bus.req = 4'b1001;
      tick();
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.q} !== {4'b0001, 4'b0001, 8'd11}) begin
         errors++;
         $display("FAIL wrap_to0: grant=%b ack=%b q=%0d, want 0001 0001 11", bus.grant, bus.ack, bus.q);
      end
      tick();
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.owner} !== {4'b1000, 4'b1000, 2'd3}) begin
         errors++;
         $display("FAIL wrap_back3: grant=%b ack=%b owner=%0d, want 1000 1000 3", bus.grant, bus.ack, bus.owner);
      end
   endtask
   task automatic test_reset_mid_hold();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 4'b0010;
      tick();
      checks++;
      if ({bus.grant, bus.q} !== {4'b0010, 8'd50}) begin
         errors++;
         $display("FAIL midrst_grant1: grant=%b q=%0d, want 0010 50", bus.grant, bus.q);
      end
      bus.req = 4'b0000;
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.q, bus.q_bar, bus.grant, bus.busy} !== {8'h00, 8'hFF, 4'b0, 1'b0}) begin
         errors++;
         $display("FAIL midrst_abort: q=%h q_bar=%h grant=%b busy=%b, want 00 ff 0000 0", bus.q, bus.q_bar, bus.grant, bus.busy);
      end
      rst = 1'b0;
      bus.req = 4'b1111;
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.owner, bus.q} !== {4'b0001, 4'b0001, 2'd0, 8'd11}) begin
         errors++;
         $display("FAIL midrst_ptr0: grant=%b ack=%b owner=%0d q=%0d, want 0001 0001 0 11", bus.grant, bus.ack, bus.owner, bus.q);
      end
   endtask
   task automatic test_owner_drop();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 4'b0110;
      tick();
      tick();
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.q} !== {4'b0100, 4'b0100, 8'd60}) begin
         errors++;
         $display("FAIL drop_grant2: grant=%b ack=%b q=%0d, want 0100 0100 60", bus.grant, bus.ack, bus.q);
      end
      bus.req = 4'b0010;
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.q} !== {4'b0100, 4'b0000, 8'd60}) begin
         errors++;
         $display("FAIL drop_hold: grant=%b ack=%b q=%0d, want 0100 0000 60", bus.grant, bus.ack, bus.q);
      end
      tick();
      checks++;
      if ({bus.grant, bus.ack, bus.owner, bus.q} !== {4'b0010, 4'b0010, 2'd1, 8'd50}) begin
         errors++;
         $display("FAIL drop_next: grant=%b ack=%b owner=%0d q=%0d, want 0010 0010 1 50", bus.grant, bus.ack, bus.owner, bus.q);
      end
      bus.req = 4'b0000;
      tick();
      tick();
      checks++;
      if ({bus.grant, bus.busy, bus.owner, bus.q} !== {4'b0, 1'b0, 2'd1, 8'd50}) begin
         errors++;
         $display("FAIL drop_idle: grant=%b busy=%b owner=%0d q=%0d, want 0000 0 1 50", bus.grant, bus.busy, bus.owner, bus.q);
      end
   endtask
   initial begin
      bus.req = '0;
      bus.data_in = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_pointer_wrap();
      test_reset_mid_hold();
      test_owner_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
